game_input_ctrl: RTL
====================

# game_input_ctrl

Button front-end for the game control path. Synchronises and debounces the three raw player buttons (start, restart, action) and converts them into single-cycle event pulses. `start_game` and `restart` feed the game state FSM directly. `action_pulse` is gated by the FSM's current `state`, so gameplay logic only sees actions while a game is running.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: cycles a synchronised input must differ from its stable level before the level flips; legal range ≥ 2.
- `CNT_W`, default 20: width of each debounce counter; must hold `DEBOUNCE_CYCLES-1`.
- `REPEAT_DELAY`, default 30000000: cycles from the first action pulse to the first auto-repeat pulse; used only with the macro.
- `REPEAT_PERIOD`, default 10000000: cycles between auto-repeat pulses; used only with the macro.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_start` in 1: raw start button, active-high, asynchronous to `clk`.
- `btn_restart` in 1: raw restart button, active-high, asynchronous.
- `btn_action` in 1: raw action/jump button, active-high, asynchronous.
- `state` in 2: game FSM state (0 = initial, 1 = playing, 2 = over).
- `start_game` out 1: one-cycle pulse on debounced start press.
- `restart` out 1: one-cycle pulse on debounced restart press.
- `action_pulse` out 1: one-cycle pulse on debounced action press, only while `state` = 1.
- `btn_level` out 3: debounced levels {action, restart, start}.

## Operation
- **Synchroniser:** each button passes through a 2-flop synchroniser; the second flop output is `s`.
- **Debounce, per button:**
  - Keep a stable level `lvl` and a counter `cnt`.
  - If `s == lvl`, set `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, set `lvl <= s` and `cnt <= 0`.
  - Else `cnt <= cnt+1`.
  - Any bounce shorter than `DEBOUNCE_CYCLES` consecutive differing samples is discarded.
- **Edge detect:** each output pulse is registered and high for exactly one cycle after a 0→1 transition of its `lvl`. Releases (1→0) produce no pulse.
- **Action gating:** the action pulse is suppressed unless `state` = 1, sampled in the same cycle the `lvl` rising edge is detected. A press that completes debounce while not playing is dropped, not deferred.
- **No gating on start/restart:** `start_game` and `restart` fire in every state.
- **Simultaneous events:** if both rise in the same cycle, both pulse. Priority is resolved downstream by the FSM (start is ignored while restart is asserted in the initial state).
- **Reset:** `rst` clears all synchroniser flops, `lvl`, counters and repeat logic to 0. All outputs read 0 during and immediately after reset. A button held through reset release is seen as a fresh press after full debounce.

## Timing
- **Latency:** a raw input held steady from edge e gives `lvl` change at edge e+1+`DEBOUNCE_CYCLES`. The pulse is high for the cycle after edge e+2+`DEBOUNCE_CYCLES`, i.e. latency `DEBOUNCE_CYCLES`+2 cycles.
- **Width:** pulses are exactly one cycle wide. At most one press pulse per button per debounced press, excluding auto-repeat.
- **Level output:** `btn_level` changes in the same cycle as the corresponding `lvl`.
- **Mid-operation reset:** asserting `rst` mid-debounce or mid-pulse aborts immediately; no pulse is emitted for that press.

## Configuration
- **Macro `GAME_INPUT_AUTOREPEAT_EN` defined:**
  - While action `lvl` stays 1 and `state` = 1, a repeat counter starts at the initial action pulse.
  - Further `action_pulse` pulses occur `REPEAT_DELAY` cycles after the initial pulse, then every `REPEAT_PERIOD` cycles.
  - The counter clears when action `lvl` falls or `state` leaves 1.
- **Macro undefined:** no repeat counter is synthesised, and a held action button yields exactly one pulse.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5.
1. **Clean press:** `state`=0, `btn_start` 0→1 held 20 cycles → `start_game` high exactly one cycle, 6 cycles after the input edge; `btn_level[0]`=1; no other pulses.
2. **Bounce rejection:** `btn_restart` toggles 1,0,1,0 on 3-cycle intervals, then holds 1 → exactly one `restart` pulse, 6 cycles after the final rising edge; none during bouncing.
3. **Action gating:** action pressed with `state`=0 → no `action_pulse`. Release, set `state`=1, press again → one `action_pulse`, 6 cycles after the input edge.
4. **Simultaneous press:** `btn_start` and `btn_restart` rise on the same edge → `start_game` and `restart` both pulse on the same cycle.
5. **Mid-debounce reset:** pulse `rst` 2 cycles after pressing `btn_start` while holding the button → no pulse from the aborted press. Exactly one `start_game` pulse 6 cycles after `rst` deasserts.
6. **Auto-repeat (macro defined):** `state`=1, action held 40 cycles → pulses at t0, t0+10, t0+15, t0+20, … until release. Changing `state` to 2 mid-hold stops pulses immediately. With the macro undefined, only the t0 pulse occurs.

Source files
------------

// File: rtl/game_input_ctrl_if.sv
// Button, game-state and event signals of the game input front-end.
// The testbench or game top drives through master; the front-end uses slave.
interface game_input_ctrl_if;
    logic       btn_start;
    logic       btn_restart;
    logic       btn_action;
    logic [1:0] state;
    logic       start_game;
    logic       restart;
    logic       action_pulse;
    logic [2:0] btn_level;

    modport master (
        output btn_start, btn_restart, btn_action, state,
        input  start_game, restart, action_pulse, btn_level
    );

    modport slave (
        input  btn_start, btn_restart, btn_action, state,
        output start_game, restart, action_pulse, btn_level
    );
endinterface

// File: rtl/game_input_ctrl.sv
// Synchronise, debounce and edge-detect the start/restart/action buttons into one-cycle events.
// Optional action auto-repeat is enabled by defining GAME_INPUT_AUTOREPEAT_EN.
module game_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 30000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    game_input_ctrl_if.slave bus
);
    localparam logic [1:0] StPlaying = 2'd1;

    if (DEBOUNCE_CYCLES < 2 || $clog2(DEBOUNCE_CYCLES) > CNT_W ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("game_input_ctrl: illegal parameter combination");
    end

    logic [2:0]       w_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_lvl;
    logic [2:0]       r_lvl_d;
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       w_rise;
    logic             w_playing;
    logic             w_action_fire;
    logic             r_start_pulse;
    logic             r_restart_pulse;
    logic             r_action_pulse;

    assign w_raw     = {bus.btn_action, bus.btn_restart, bus.btn_start};
    assign w_playing = (bus.state == StPlaying);
    assign w_rise    = r_lvl & ~r_lvl_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // A level only flips after DEBOUNCE_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvl <= '0;
            for (int b = 0; b < 3; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 3; b++) begin
                if (r_sync2[b] == r_lvl[b]) begin
                    r_cnt[b] <= '0;
                end else if (r_cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_lvl[b] <= r_sync2[b];
                    r_cnt[b] <= '0;
                end else begin
                    r_cnt[b] <= r_cnt[b] + CNT_W'(1);
                end
            end
        end
    end

`ifdef GAME_INPUT_AUTOREPEAT_EN
    localparam int RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RptW   = $clog2(RptMax + 1);

    logic            r_rep_on;
    logic            r_rep_first;
    logic [RptW-1:0] r_rep_cnt;
    logic [RptW-1:0] w_rep_limit;
    logic            w_first_press;
    logic            w_rep_fire;

    assign w_first_press = w_rise[2] & w_playing;
    assign w_rep_limit   = r_rep_first ? RptW'(REPEAT_DELAY) : RptW'(REPEAT_PERIOD);
    assign w_rep_fire    = r_rep_on & r_lvl[2] & w_playing & (r_rep_cnt == w_rep_limit);
    assign w_action_fire = w_first_press | w_rep_fire;

    // The count is the number of cycles since the last emitted action pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rep_on    <= 1'b0;
            r_rep_first <= 1'b0;
            r_rep_cnt   <= '0;
        end else if (w_first_press) begin
            r_rep_on    <= 1'b1;
            r_rep_first <= 1'b1;
            r_rep_cnt   <= RptW'(1);
        end else if (r_rep_on) begin
            if (!(r_lvl[2] && w_playing)) begin
                r_rep_on  <= 1'b0;
                r_rep_cnt <= '0;
            end else if (w_rep_fire) begin
                r_rep_first <= 1'b0;
                r_rep_cnt   <= RptW'(1);
            end else begin
                r_rep_cnt <= r_rep_cnt + RptW'(1);
            end
        end
    end
`else
    assign w_action_fire = w_rise[2] & w_playing;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvl_d         <= '0;
            r_start_pulse   <= 1'b0;
            r_restart_pulse <= 1'b0;
            r_action_pulse  <= 1'b0;
        end else begin
            r_lvl_d         <= r_lvl;
            r_start_pulse   <= w_rise[0];
            r_restart_pulse <= w_rise[1];
            r_action_pulse  <= w_action_fire;
        end
    end

    assign bus.start_game   = r_start_pulse;
    assign bus.restart      = r_restart_pulse;
    assign bus.action_pulse = r_action_pulse;
    assign bus.btn_level    = r_lvl;
endmodule
